led_pattern_gen: RTL
====================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised successor to the fixed 4-LED fabric blinker. Drives NUM_LEDS outputs from FAB_CLK.
//  Each channel has its own mode: off, on, blink or 8-bit PWM, set over a simple write-only config port.
//  Sits beside the MSS: clocked from FAB_CCC GL0, enabled by MSS_READY on FAB_LOCK, configured by fabric/APB glue.
//  Out of reset it reproduces the legacy behaviour: all channels blink.
// PARAMETERS
//  NUM_LEDS      4     number of LED channels (1..7)
//  PRESCALE_DIV  50000 FAB_CLK cycles per tick (>=2)
//  PRESCALE_W    24    prescaler counter width; must hold PRESCALE_DIV-1
//  RESET_PARAM   250   per-channel blink half-period (ticks) loaded at reset
//  ADDR_W        3     CFG_ADDR width; must address 0..NUM_LEDS
// PORTS
//  FAB_CLK    in   1         single clock, rising edge
//  FAB_RESET  in   1         synchronous active-high reset
//  FAB_LOCK   in   1         run enable (CCC lock / MSS ready); low = outputs dark, counters held
//  CFG_WE     in   1         config write strobe, one cycle
//  CFG_ADDR   in   ADDR_W    0..NUM_LEDS-1 = channel reg; NUM_LEDS = global ctrl reg
//  CFG_WDATA  in   10        channel: [9:8] mode, [7:0] param; ctrl: [0] chase_on, [9:2] chase step
//  LED        out  NUM_LEDS  registered LED drives, active-high
//  TICK       out  1         one-cycle pulse per prescaler wrap (debug/sync)
// BEHAVIOUR
//  Reset (FAB_RESET=1 at clock edge): LED=0, TICK=0, prescaler=0, PWM phase=0, all blink counters/states=0.
//   Every channel: mode=2'b10 (blink), param=RESET_PARAM. Ctrl reg=0.
//   Reset dominates all other inputs, including a concurrent CFG_WE.
//  FAB_LOCK=0: prescaler, phase, blink counters and chase position held at 0. LED=0, TICK=0.
//   Config writes are still accepted.
//  Prescaler: counts 0..PRESCALE_DIV-1 while locked. TICK=1 on the cycle the count wraps to 0.
//   First TICK occurs PRESCALE_DIV cycles after FAB_LOCK rises.
//  Modes per channel (LED is registered: 1 cycle after internal state):
//   00 off: LED=0.  01 on: LED=1.
//   10 blink: counter increments on TICK. When counter reaches max(param,1)-1 on a TICK, it clears and state toggles.
//      LED=state. Half-period = max(param,1)*PRESCALE_DIV clocks.
//   11 PWM: shared 8-bit phase increments every locked cycle and wraps 255->0.
//      LED=(phase<param). param=0 always off; param=255 is on 255/256.
//  Config write (CFG_WE=1): channel reg updates at that edge.
//   That channel's blink counter and state clear to 0, so a write on a TICK edge wins over the tick.
//   New mode is visible on LED 1 cycle later.
//   Addresses > NUM_LEDS are ignored. No read-back.
//  Counter widths: blink counters 8 bit; no overflow is possible since max(param,1)-1 <= 254.
// CONFIGURATION
//  LED_PATTERN_CHASE_EN defined: ctrl reg (addr NUM_LEDS) is writable.
//   When chase_on=1, channel modes are overridden and LED is one-hot at position pos.
//   pos advances every max(step,1) TICKs and wraps NUM_LEDS-1 -> 0.
//   Writing chase_on clears pos and the step counter to 0. Clearing chase_on returns to the per-channel modes next cycle.
//   FAB_LOCK=0 holds pos at 0.
//  LED_PATTERN_CHASE_EN undefined: ctrl reg writes are ignored; chase logic is absent; behaviour is per-channel only.
// TESTING (NUM_LEDS=4, PRESCALE_DIV=4, RESET_PARAM=2)
//  1 Reset, then FAB_LOCK=1 -> TICK every 4 clk; all LED toggle together every 8 clk, first rise at ~clk 9.
//  2 Write ch1 mode 01 and ch2 mode 00 -> LED[1]=1 and LED[2]=0 one cycle after write; ch0/ch3 keep blinking.
//  3 Write ch3 mode 11, param 64 -> LED[3] high 64 of every 256 clk; then param 0 -> stuck 0; param 255 -> 255/256.
//  4 FAB_LOCK low mid-blink -> LED=0 next cycle, TICK stops; relock -> first TICK after 4 clk, blink restarts from 0.
//  5 Write ch0 blink param 3 on the same edge as a TICK -> counter cleared and no toggle; toggles every 12 clk after that.
//  6 CHASE_EN: write ctrl step 1, chase_on -> LED 0001,0010,0100,1000,0001 every 4 clk. Without macro -> LED unchanged.

Source files
------------

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: write-only config port plus LED/TICK outputs of led_pattern_gen.
interface led_pattern_gen_if #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned ADDR_W   = 3
) ();
  localparam int unsigned WDATA_W = 10;

  logic                CFG_WE;
  logic [ADDR_W-1:0]   CFG_ADDR;
  logic [WDATA_W-1:0]  CFG_WDATA;
  logic [NUM_LEDS-1:0] LED;
  logic                TICK;

  modport master (
    output CFG_WE, CFG_ADDR, CFG_WDATA,
    input  LED, TICK
  );

  modport slave (
    input  CFG_WE, CFG_ADDR, CFG_WDATA,
    output LED, TICK
  );
endinterface

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: per-channel off/on/blink/PWM LED driver with a shared tick prescaler.
// Optional chase overlay on the global ctrl register is compiled in by LED_PATTERN_CHASE_EN.
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS     = 4,
  parameter int unsigned PRESCALE_DIV = 50000,
  parameter int unsigned PRESCALE_W   = 24,
  parameter int unsigned RESET_PARAM  = 250,
  parameter int unsigned ADDR_W       = 3
) (
  input logic              FAB_CLK,
  input logic              FAB_RESET,
  input logic              FAB_LOCK,
  led_pattern_gen_if.slave bus
);
  localparam int unsigned PARAM_W = 8;
  localparam int unsigned PHASE_W = 8;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PWM   = 2'b11;

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE_DIV - 1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [1:0]            mode_q  [NUM_LEDS];
  logic [1:0]            mode_d  [NUM_LEDS];
  logic [PARAM_W-1:0]    param_q [NUM_LEDS];
  logic [PARAM_W-1:0]    param_d [NUM_LEDS];
  logic [PARAM_W-1:0]    cnt_q   [NUM_LEDS];
  logic [PARAM_W-1:0]    cnt_d   [NUM_LEDS];
  logic [NUM_LEDS-1:0]   state_q, state_d;
  logic [NUM_LEDS-1:0]   led_d;
  logic                  tick_d;
  logic                  tick_c;

  // Last counter value of a blink half-period; param 0 behaves like 1.
  function automatic logic [PARAM_W-1:0] blink_last(input logic [PARAM_W-1:0] p);
    return (p == '0) ? '0 : p - PARAM_W'(1);
  endfunction

  assign tick_c = FAB_LOCK && (presc_q == PRESC_LAST);

`ifdef LED_PATTERN_CHASE_EN
  localparam int unsigned POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic               chase_on_q, chase_on_d;
  logic [PARAM_W-1:0] step_q, step_d;
  logic [PARAM_W-1:0] scnt_q, scnt_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               ctrl_we_c;

  assign ctrl_we_c = bus.CFG_WE && (bus.CFG_ADDR == ADDR_W'(NUM_LEDS));

  // Chase position advances every max(step,1) ticks; a ctrl write restarts it.
  always_comb begin
    chase_on_d = chase_on_q;
    step_d     = step_q;
    scnt_d     = scnt_q;
    pos_d      = pos_q;
    if (!FAB_LOCK) begin
      scnt_d = '0;
      pos_d  = '0;
    end else if (chase_on_q && tick_c) begin
      if (scnt_q == blink_last(step_q)) begin
        scnt_d = '0;
        pos_d  = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
      end else begin
        scnt_d = scnt_q + PARAM_W'(1);
      end
    end
    if (ctrl_we_c) begin
      chase_on_d = bus.CFG_WDATA[0];
      step_d     = bus.CFG_WDATA[9:2];
      scnt_d     = '0;
      pos_d      = '0;
    end
  end

  // Chase state registers.
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      chase_on_q <= 1'b0;
      step_q     <= '0;
      scnt_q     <= '0;
      pos_q      <= '0;
    end else begin
      chase_on_q <= chase_on_d;
      step_q     <= step_d;
      scnt_q     <= scnt_d;
      pos_q      <= pos_d;
    end
  end
`endif

  // Prescaler, PWM phase, per-channel blink and config next-state plus LED decode.
  always_comb begin
    presc_d = presc_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    param_d = param_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    led_d   = '0;
    tick_d  = 1'b0;

    if (!FAB_LOCK) begin
      presc_d = '0;
      phase_d = '0;
      state_d = '0;
      for (int i = 0; i < NUM_LEDS; i++) cnt_d[i] = '0;
    end else begin
      tick_d  = tick_c;
      presc_d = tick_c ? '0 : presc_q + PRESCALE_W'(1);
      phase_d = phase_q + PHASE_W'(1);
      for (int i = 0; i < NUM_LEDS; i++) begin
        case (mode_q[i])
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = state_q[i];
          MODE_PWM:   led_d[i] = (phase_q < param_q[i]);
          default:    led_d[i] = 1'b0;
        endcase
        if (tick_c) begin
          if (cnt_q[i] == blink_last(param_q[i])) begin
            cnt_d[i]   = '0;
            state_d[i] = ~state_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + PARAM_W'(1);
          end
        end
      end
`ifdef LED_PATTERN_CHASE_EN
      if (chase_on_q) led_d = NUM_LEDS'(1) << pos_q;
`endif
    end

    // A channel write beats a concurrent tick on that channel.
    if (bus.CFG_WE) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (bus.CFG_ADDR == ADDR_W'(i)) begin
          mode_d[i]  = bus.CFG_WDATA[9:8];
          param_d[i] = bus.CFG_WDATA[7:0];
          cnt_d[i]   = '0;
          state_d[i] = 1'b0;
        end
      end
    end
  end

  // State and output registers; reset restores the all-blink legacy pattern.
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      presc_q  <= '0;
      phase_q  <= '0;
      state_q  <= '0;
      bus.LED  <= '0;
      bus.TICK <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]  <= MODE_BLINK;
        param_q[i] <= PARAM_W'(RESET_PARAM);
        cnt_q[i]   <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      state_q  <= state_d;
      bus.LED  <= led_d;
      bus.TICK <= tick_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i]  <= mode_d[i];
        param_q[i] <= param_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
endmodule
